uart_fifo_gen: RTL
==================

# uart_fifo_gen

Parametrised synchronous FIFO that replaces the fixed 8-bit/16-entry UART FIFO. It supports any data width and any power-of-two depth, and has a selectable standard or first-word-fall-through (FWFT) read mode. It adds an occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags. It sits between the UART RX/TX datapaths and the host/bus interface, one instance per direction.

## Interface
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 4: pointer width; DEPTH = 2**ADDR_WIDTH entries.
- AFULL_THRESH, 12: almost_full asserts when count >= AFULL_THRESH (legal range 1..DEPTH).
- AEMPTY_THRESH, 2: almost_empty asserts when count <= AEMPTY_THRESH (legal range 0..DEPTH-1).
- FWFT, 0: read mode. 0 = standard (registered dout); 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous empty: clears pointers and count.
- err_clr  in  1  synchronous clear of overflow/underflow.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- rd_en  in  1  read (pop) request.
- dout  out  DATA_WIDTH  read data.
- dout_valid  out  1  FWFT=0: one-cycle pulse, dout updated. FWFT=1: equals !empty.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  out  1  status flags.
- overflow, underflow  out  1  sticky error flags.

## Operation
- Storage is a DEPTH x DATA_WIDTH register array. It is not reset.
- wr_ptr, rd_ptr: ADDR_WIDTH bits, wrap DEPTH-1 -> 0 naturally.
- count register is ADDR_WIDTH+1 bits and is the single source of truth for all flags.
- Flag definitions, all combinational from count:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count >= AFULL_THRESH)
  - almost_empty = (count <= AEMPTY_THRESH)
- Acceptance, evaluated on pre-edge state:
  - rd_acc = rd_en & !empty & !flush
  - wr_acc = wr_en & !flush & (!full | rd_acc)
- Full with wr_en & rd_en: both are accepted. The read frees the head slot, the write lands at wr_ptr (== rd_ptr pre-edge), and count is unchanged.
- Empty with wr_en & rd_en: write is accepted, read is rejected, underflow is set, count becomes 1.
- Count update: count + wr_acc - rd_acc.
- overflow sets on wr_en & !wr_acc & !flush. underflow sets on rd_en & !rd_acc & !flush.
- err_clr clears both error flags. If a set condition and err_clr occur in the same cycle, the set wins.
- flush sets wr_ptr, rd_ptr and count to 0 and dout_valid to 0. Same-cycle wr_en/rd_en are ignored and raise no error. dout holds its value. Error flags are unaffected.
- FWFT=0 read path: on rd_acc, dout <= mem[rd_ptr] and dout_valid <= 1; otherwise dout_valid <= 0 and dout holds.
- FWFT=1 read path: dout = mem[rd_ptr] combinationally. dout is valid whenever !empty, and rd_en acknowledges the current word.
- Reset values: count=0, empty=1, almost_empty=1, full=0, almost_full=0 (given legal thresholds), dout=0 (FWFT=0), dout_valid=0, overflow=0, underflow=0, both pointers 0.
- Reset applied mid-operation discards all contents immediately, asynchronously.

## Timing
- Write latency: a write accepted at edge N is reflected in count and flags after edge N.
  - FWFT=1: a write into an empty FIFO appears on dout after edge N, with dout_valid high.
- Read latency, FWFT=0: rd_en high in the cycle before edge N gives dout and dout_valid=1 after edge N. dout_valid lasts exactly one cycle per accepted read.
- Read latency, FWFT=1: zero; the next word appears on dout after the popping edge.
- Throughput: one write and one read per cycle sustained, with no bubbles at wrap-around.
- Error flags become visible one cycle after the offending request.
- Reset release: writes are accepted from the first clk edge after rst deasserts.

## Test plan
- **Reset/fill/drain, FWFT=0, DW=8, AW=4:** write 0x00..0x0F on 16 cycles.
  - Expect count=16, full=1, almost_full high from count=12.
  - Read 16: dout sequence 0x00..0x0F, each one cycle after its rd_en. empty=1 at the end, no errors.
- **Wrap-around:** write 10, read 10, write 12, read 12. Data is in order across the pointer wrap and count returns to 0.
- **Boundary simultaneity:**
  - At full, wr_en=rd_en=1 with din=0xAA: count stays 16, no overflow, and 0xAA is read last.
  - At empty, wr_en=rd_en=1 with din=0x55: count=1, underflow=1, next read returns 0x55.
- **Errors/err_clr:** a write when full (no read) sets overflow=1; data is unchanged. err_clr clears it. err_clr together with another bad write leaves overflow=1.
- **Flush:** with count=7, pulse flush together with wr_en: count=0, empty=1, no overflow. The next write/read round-trips correctly.
- **FWFT=1, DW=12, AW=3:** write 0x123.
  - dout=0x123 the next cycle with dout_valid=1.
  - Pop with rd_en: dout_valid=0 and empty=1 after the edge.
  - Assert rst mid-burst: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/uart_fifo_gen.sv
// uart_fifo_gen: parametrised synchronous FIFO for the UART RX/TX paths.
// Any data width, power-of-two depth, standard or first-word-fall-through
// read mode, occupancy count, almost-full/almost-empty thresholds,
// synchronous flush and sticky overflow/underflow flags.
//
// Handshake: a write is taken on a rising edge when wr_en is high, flush is
// low and the FIFO is not full (or a read is taken on the same edge). A read
// is taken when rd_en is high, flush is low and the FIFO is not empty. A
// request that cannot be taken is dropped and raises the matching sticky
// error flag. In standard mode dout_valid pulses for one cycle after each
// taken read. In FWFT mode dout_valid mirrors !empty, and rd_en acknowledges
// the word currently on dout.
module uart_fifo_gen #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  err_clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_set;
  logic                  unf_set;

  // All status flags derive from the occupancy register alone.
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

  // A read at full frees the head slot, so a same-cycle write still fits.
  assign rd_acc  = rd_en & ~empty & ~flush;
  assign wr_acc  = wr_en & ~flush & (~full | rd_acc);
  assign ovf_set = wr_en & ~wr_acc & ~flush;
  assign unf_set = rd_en & ~rd_acc & ~flush;

  // Storage array: written on accepted writes, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (unf_set)      underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  dv_q;

      // Registered read port: dout updates and dout_valid pulses per read.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q <= '0;
          dv_q   <= 1'b0;
        end else if (flush) begin
          dv_q   <= 1'b0;
        end else if (rd_acc) begin
          dout_q <= mem[rd_ptr];
          dv_q   <= 1'b1;
        end else begin
          dv_q   <= 1'b0;
        end
      end

      assign dout       = dout_q;
      assign dout_valid = dv_q;
    end else begin : g_fwft
      // Head word is presented combinationally; valid whenever not empty.
      assign dout       = mem[rd_ptr];
      assign dout_valid = ~empty;
    end
  endgenerate

endmodule
